j0_mem_bridge: RTL and testbench
================================

Name: j0_mem_bridge

Overview:
- Sits directly downstream of the J0 coprocessor's data-memory port.
- Converts each 16-bit J0 load/store into two little-endian byte accesses on the shared 8-bit main-RAM arbiter port.
- Stalls J0 through its pause input until the word transfer completes.
- Passes accesses with addr[15]=1 straight to the zero-wait I/O register space with no stall.

Parameters:
RAM_AW, 15, byte-address width of the shared RAM port
IO_SEL_BIT, 15, cpu_addr bit that selects the I/O region when 1

Ports:
sys_clk_i  in  1  system clock
sys_rst_i  in  1  synchronous active-high reset
cpu_rd  in  1  J0 load request (J0 mem_rd), level, held while paused
cpu_wr  in  1  J0 store request (J0 mem_wr), level, held while paused
cpu_addr  in  16  J0 byte address (J0 mem_addr); bit0 ignored, word forced even
cpu_dout  in  16  J0 store data (J0 mem_dout)
cpu_din  out  16  load data to J0 (J0 mem_din)
cpu_pause  out  1  stall to J0 (J0 pause)
ram_req  out  1  byte access request to the arbiter
ram_gnt  in  1  arbiter grant, meaningful only while ram_req=1
ram_we  out  1  1=write, 0=read
ram_addr  out  RAM_AW  byte address
ram_wdata  out  8  write byte
ram_rdata  in  8  read byte, valid exactly 1 cycle after the granted read cycle
io_rd  out  1  I/O read strobe
io_wr  out  1  I/O write strobe
io_addr  out  15  I/O address = cpu_addr[14:0]
io_wdata  out  16  = cpu_dout
io_din  in  16  I/O read data, combinational, same cycle

Behaviour:
- States: IDLE, RD_LO, RD_HI, RD_FIN, WR_LO, WR_HI, DONE.
- Reset: state=IDLE, latched word=0. ram_req=0, ram_we=0, io_rd=io_wr=0, cpu_pause=0 while sys_rst_i=1.
- Reset mid-transfer aborts immediately: ram_req drops in the reset cycle and no further byte is issued.
- RAM access condition: ram_acc = (cpu_rd|cpu_wr) & !cpu_addr[IO_SEL_BIT].
- cpu_pause = ram_acc & (state != DONE). It is combinational, so the stall is asserted in the first cycle of the access.
- Read sequence:
  - IDLE drives ram_req=1, ram_we=0, addr A=cpu_addr[RAM_AW-1:1]<<1. On gnt it goes to RD_HI; without gnt it goes to RD_LO.
  - RD_LO holds the low-byte request until gnt, then goes to RD_HI.
  - RD_HI captures ram_rdata into the low byte on its first cycle only. It holds the request at A+1 until gnt, then goes to RD_FIN.
  - RD_FIN captures ram_rdata into the high byte and goes to DONE.
- Write sequence:
  - IDLE drives ram_req=1, ram_we=1, addr A, ram_wdata=cpu_dout[7:0]. On gnt it goes to WR_HI; without gnt it goes to WR_LO.
  - WR_LO holds the low-byte request until gnt, then goes to WR_HI.
  - WR_HI drives A+1, ram_wdata=cpu_dout[15:8], holds until gnt, then goes to DONE.
- DONE: cpu_pause=0, cpu_din = latched word, and J0 advances at this edge. The next state is IDLE unconditionally, so the still-visible request is never re-triggered.
- Uncontended latency: read is 4 cycles (3 stalled); write is 3 cycles (2 stalled).
- Request hold: ram_addr, ram_we and ram_wdata stay stable while ram_req=1 until gnt. ram_req is 0 in RD_FIN, DONE and IDLE without ram_acc.
- Simultaneous cpu_rd and cpu_wr to RAM: the write sequence only. In DONE, cpu_din = cpu_dout (write-through).
- I/O region: io_rd = cpu_rd & sel, io_wr = cpu_wr & sel. cpu_din = io_din in the same cycle and no pause is asserted. A strobe lasts exactly one cycle because J0 is not stalled.
- cpu_din mux: io_din when sel and cpu_rd; otherwise the latched word.
- Address wrap: A+1 is computed in RAM_AW bits. A is always even, so it never carries out.
- A grant arriving while ram_req=0 is ignored.

Decomposition:
- Shared package j0_pkg:
  - state enum (7 states).
  - IO_SEL_BIT default.
  - RAM_AW default.
  - byte-lane constants LO=0, HI=1.
- No sub-module: single always_ff for the state machine and latch, plus one combinational block for outputs.

Test Plan:
- RAM[0x0100]=0x34, RAM[0x0101]=0x12, gnt always 1, cpu_rd addr 0x0100 -> pause for 3 cycles, then cpu_din=0x1234 with pause=0 in cycle 4; requests at addresses 0x0100 then 0x0101.
- Same read with gnt withheld 2 cycles on the low byte and 1 cycle on the high byte -> addr and req held stable, pause for 6 cycles, cpu_din=0x1234.
- cpu_wr addr 0x0201 (odd), dout=0xBEEF -> bytes written 0x0200=0xEF, 0x0201=0xBE; pause for 2 cycles.
- cpu_rd addr 0x8004, io_din=0x5A5A -> io_rd=1 for 1 cycle, io_addr=0x0004, cpu_din=0x5A5A, pause never asserted, ram_req=0.
- Back-to-back reads at 0x0100 then 0x0102 -> DONE goes to IDLE, the second read starts the next cycle, and each read returns the correct word.
- sys_rst_i asserted in RD_HI -> ram_req=0 in that same cycle, state=IDLE, pause=0. After release, a fresh read returns correct data.

Source files
------------

// File: rtl/j0_pkg.sv
// Shared definitions for the J0 data-memory bridge.
// Contents: FSM state encoding, default RAM/I/O geometry, byte-lane indices.
// No ports; imported by j0_mem_bridge.
package j0_pkg;

  // Default byte-address width of the shared 8-bit RAM port.
  localparam int RAM_AW_DEF = 15;

  // cpu_addr bit that routes an access to the I/O register space.
  localparam int IO_SEL_BIT_DEF = 15;

  // Little-endian byte lanes within a 16-bit J0 word.
  localparam int LO = 0;
  localparam int HI = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_RD_FIN,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_t;

endpackage

// File: rtl/j0_mem_bridge.sv
// J0 data-memory bridge: splits each 16-bit J0 load/store into two
// little-endian byte accesses on the shared 8-bit RAM arbiter port and stalls
// J0 until the word completes; addr[IO_SEL_BIT]=1 goes to zero-wait I/O space.
// Ports: sys_clk_i/sys_rst_i (sync active-high); cpu_* = J0 data port
// (rd/wr/addr/dout in, din/pause out); ram_* = arbiter req/gnt byte port with
// 1-cycle read data; io_* = I/O strobes, address, write data and comb read data.
module j0_mem_bridge
  import j0_pkg::*;
#(
  parameter int RAM_AW     = RAM_AW_DEF,
  parameter int IO_SEL_BIT = IO_SEL_BIT_DEF
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [15:0]       cpu_addr,
  input  logic [15:0]       cpu_dout,
  output logic [15:0]       cpu_din,
  output logic              cpu_pause,
  output logic              ram_req,
  input  logic              ram_gnt,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              io_rd,
  output logic              io_wr,
  output logic [14:0]       io_addr,
  output logic [15:0]       io_wdata,
  input  logic [15:0]       io_din
);

  state_t      state;
  logic [15:0] word;
  // Set on entry to RD_HI: the low byte read was granted last cycle, so
  // ram_rdata holds it only during the first RD_HI cycle.
  logic        lo_pend;

  logic              sel;
  logic              ram_acc;
  logic [RAM_AW-1:0] a_lo;
  logic [RAM_AW-1:0] a_hi;

  assign sel     = cpu_addr[IO_SEL_BIT];
  assign ram_acc = (cpu_rd | cpu_wr) & ~sel;

  // Word address is forced even, so the high byte is just bit0 set: no carry.
  assign a_lo = {cpu_addr[RAM_AW-1:1], 1'(LO)};
  assign a_hi = {cpu_addr[RAM_AW-1:1], 1'(HI)};

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state   <= S_IDLE;
      word    <= '0;
      lo_pend <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ram_acc) begin
            // A simultaneous rd+wr runs the write sequence only.
            if (cpu_wr) begin
              state <= ram_gnt ? S_WR_HI : S_WR_LO;
            end else if (ram_gnt) begin
              state   <= S_RD_HI;
              lo_pend <= 1'b1;
            end else begin
              state <= S_RD_LO;
            end
          end
        end
        S_RD_LO: begin
          if (ram_gnt) begin
            state   <= S_RD_HI;
            lo_pend <= 1'b1;
          end
        end
        S_RD_HI: begin
          if (lo_pend) begin
            word[LO*8 +: 8] <= ram_rdata;
          end
          lo_pend <= 1'b0;
          if (ram_gnt) begin
            state <= S_RD_FIN;
          end
        end
        S_RD_FIN: begin
          word[HI*8 +: 8] <= ram_rdata;
          state           <= S_DONE;
        end
        S_WR_LO: begin
          if (ram_gnt) begin
            state <= S_WR_HI;
          end
        end
        S_WR_HI: begin
          if (ram_gnt) begin
            // Write-through: J0 sees its own store data in DONE.
            word  <= cpu_dout;
            state <= S_DONE;
          end
        end
        // J0 advances on the DONE edge; returning to IDLE unconditionally
        // keeps the still-visible request from starting a second transfer.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_req   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = a_lo;
    ram_wdata = cpu_dout[LO*8 +: 8];
    case (state)
      S_IDLE: begin
        ram_req = ram_acc;
        ram_we  = cpu_wr;
      end
      S_RD_LO: ram_req = 1'b1;
      S_RD_HI: begin
        ram_req  = 1'b1;
        ram_addr = a_hi;
      end
      S_WR_LO: begin
        ram_req = 1'b1;
        ram_we  = 1'b1;
      end
      S_WR_HI: begin
        ram_req   = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = a_hi;
        ram_wdata = cpu_dout[HI*8 +: 8];
      end
      default: ;
    endcase
    // Reset drops the request in the very cycle it is asserted.
    if (sys_rst_i) begin
      ram_req = 1'b0;
      ram_we  = 1'b0;
    end
  end

  // Stall is combinational so J0 is held from the first cycle of the access.
  assign cpu_pause = ram_acc & (state != S_DONE) & ~sys_rst_i;

  // I/O space is zero-wait: J0 never stalls, so each strobe is one cycle.
  assign io_rd    = cpu_rd & sel & ~sys_rst_i;
  assign io_wr    = cpu_wr & sel & ~sys_rst_i;
  assign io_addr  = cpu_addr[14:0];
  assign io_wdata = cpu_dout;

  assign cpu_din = (sel & cpu_rd) ? io_din : word;

endmodule

// File: tb/tb_j0_mem_bridge.sv
// Randomized self-checking bench for j0_mem_bridge: acts as J0 and as the
// RAM arbiter/memory, predicting each transaction's result, stall length and
// byte-access sequence from the word-level behaviour of the bridge.
module tb_j0_mem_bridge;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        cpu_rd, cpu_wr;
  logic [15:0] cpu_addr, cpu_dout, cpu_din;
  logic        cpu_pause;
  logic        ram_req, ram_gnt, ram_we;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        io_rd, io_wr;
  logic [14:0] io_addr;
  logic [15:0] io_wdata, io_din;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [0:32767];

  always #5 clk = ~clk;

  j0_mem_bridge dut (
    .sys_clk_i(clk),      .sys_rst_i(sys_rst),
    .cpu_rd(cpu_rd),      .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr),  .cpu_dout(cpu_dout),
    .cpu_din(cpu_din),    .cpu_pause(cpu_pause),
    .ram_req(ram_req),    .ram_gnt(ram_gnt),
    .ram_we(ram_we),      .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .io_rd(io_rd),        .io_wr(io_wr),
    .io_addr(io_addr),    .io_wdata(io_wdata),
    .io_din(io_din)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One J0 transaction, cycle by cycle, with the bench granting each byte
  // after w_lo / w_hi wait cycles. rst_cyc >= 0 asserts reset in that cycle.
  task automatic run_txn(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] dout, input int w_lo, input int w_hi,
                         input logic [15:0] iodat, input int rst_cyc,
                         output logic [15:0] din_o, output int stall_o,
                         output logic [14:0] a0_o, output logic [14:0] a1_o);
    logic        sel;
    logic [14:0] a;
    logic [15:0] exp_din;
    int          exp_stall, b, waited, stall;
    bit          done;
    logic        pend;
    logic [14:0] pend_a;
    sel       = addr[15];
    a         = {addr[14:1], 1'b0};
    exp_din   = wr ? dout : {mem[a + 15'd1], mem[a]};
    exp_stall = (w_lo + 1) + (w_hi + 1) + (wr ? 0 : 1);
    b = 0; waited = 0; stall = 0; done = 0; pend = 0; pend_a = '0;
    din_o = '0; a0_o = '0; a1_o = '0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(posedge clk); #1;
      cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_dout = dout; io_din = iodat;
      ram_rdata = pend ? mem[pend_a] : 8'($urandom);
      pend = 0;
      if (cyc == rst_cyc) sys_rst = 1'b1;
      #1;
      ram_gnt = 1'b0;
      if (ram_req) begin
        if (b < 2) begin
          chk("ram_addr", 32'(ram_addr), 32'(a + 15'(b)));
          chk("ram_we", 32'(ram_we), 32'(wr));
          if (wr) chk("ram_wdata", 32'(ram_wdata), 32'(b == 0 ? dout[7:0] : dout[15:8]));
          if (waited == (b == 0 ? w_lo : w_hi)) begin
            ram_gnt = 1'b1;
            if (wr) mem[ram_addr] = ram_wdata;
            else begin pend = 1; pend_a = ram_addr; end
            if (b == 0) a0_o = ram_addr; else a1_o = ram_addr;
            b++;
            waited = 0;
          end else begin
            waited++;
          end
        end else begin
          chk("extra_req", 32'(ram_req), 32'd0);
        end
      end else begin
        ram_gnt = 1'($urandom); // stray grants must be ignored
      end
      @(negedge clk);
      if (sys_rst) begin
        chk("rst_req", 32'(ram_req), 32'd0);
        chk("rst_pause", 32'(cpu_pause), 32'd0);
        done = 1;
      end else if (sel) begin
        chk("io_rd", 32'(io_rd), 32'(rd));
        chk("io_wr", 32'(io_wr), 32'(wr));
        chk("io_addr", 32'(io_addr), 32'(addr[14:0]));
        chk("io_wdata", 32'(io_wdata), 32'(dout));
        chk("io_pause", 32'(cpu_pause), 32'd0);
        chk("io_ram_req", 32'(ram_req), 32'd0);
        if (rd) chk("io_din", 32'(cpu_din), 32'(iodat));
        din_o = cpu_din;
        done = 1;
      end else if (cpu_pause) begin
        stall++;
      end else begin
        chk("cpu_din", 32'(cpu_din), 32'(exp_din));
        chk("stall", 32'(stall), 32'(exp_stall));
        chk("bytes", 32'(b), 32'd2);
        din_o = cpu_din;
        done = 1;
      end
    end
    chk("timeout", 32'(done), 32'd1);
    stall_o = stall;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    sys_rst = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    #1 ram_gnt = 1'($urandom);
    @(negedge clk);
    chk("idle_req", 32'(ram_req), 32'd0);
    chk("idle_pause", 32'(cpu_pause), 32'd0);
    chk("idle_io", 32'({io_rd, io_wr}), 32'd0);
  endtask

  initial begin
    logic [15:0] din, addr;
    logic [14:0] a0, a1;
    int          stall, k;
    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    mem[15'h0100] = 8'h34; mem[15'h0101] = 8'h12;
    mem[15'h0102] = 8'hCD; mem[15'h0103] = 8'hAB;

    // Reset with a RAM read already presented: no request, no stall.
    sys_rst = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0100;
    cpu_dout = '0; io_din = '0; ram_gnt = 1'b1; ram_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_req", 32'(ram_req), 32'd0);
      chk("reset_we", 32'(ram_we), 32'd0);
      chk("reset_pause", 32'(cpu_pause), 32'd0);
      chk("reset_io", 32'({io_rd, io_wr}), 32'd0);
    end
    chk("reset_din", 32'(cpu_din), 32'd0);
    idle_cycle();

    // Uncontended read.
    run_txn(1, 0, 16'h0100, 16'h0, 0, 0, 16'h0, -1, din, stall, a0, a1);
    chk("lit_rd_din", 32'(din), 32'h1234);
    chk("lit_rd_stall", 32'(stall), 32'd3);
    chk("lit_rd_a0", 32'(a0), 32'h0100);
    chk("lit_rd_a1", 32'(a1), 32'h0101);
    idle_cycle();

    // Contended read: low byte waits 2, high byte waits 1.
    run_txn(1, 0, 16'h0100, 16'h0, 2, 1, 16'h0, -1, din, stall, a0, a1);
    chk("lit_rdw_din", 32'(din), 32'h1234);
    chk("lit_rdw_stall", 32'(stall), 32'd6);
    idle_cycle();

    // Odd-address write.
    run_txn(0, 1, 16'h0201, 16'hBEEF, 0, 0, 16'h0, -1, din, stall, a0, a1);
    chk("lit_wr_stall", 32'(stall), 32'd2);
    chk("lit_wr_lo", 32'(mem[15'h0200]), 32'hEF);
    chk("lit_wr_hi", 32'(mem[15'h0201]), 32'hBE);

    // I/O read.
    run_txn(1, 0, 16'h8004, 16'h0, 0, 0, 16'h5A5A, -1, din, stall, a0, a1);
    chk("lit_io_din", 32'(din), 32'h5A5A);

    // Back-to-back reads, no gap.
    run_txn(1, 0, 16'h0100, 16'h0, 0, 0, 16'h0, -1, din, stall, a0, a1);
    chk("lit_b2b_1", 32'(din), 32'h1234);
    run_txn(1, 0, 16'h0102, 16'h0, 0, 0, 16'h0, -1, din, stall, a0, a1);
    chk("lit_b2b_2", 32'(din), 32'hABCD);
    chk("lit_b2b_stall", 32'(stall), 32'd3);

    // Reset during RD_HI, then a fresh read.
    run_txn(1, 0, 16'h0100, 16'h0, 0, 0, 16'h0, 1, din, stall, a0, a1);
    idle_cycle();
    run_txn(1, 0, 16'h0100, 16'h0, 0, 0, 16'h0, -1, din, stall, a0, a1);
    chk("lit_post_rst", 32'(din), 32'h1234);

    // Randomized mix of RAM reads, writes, rd+wr, and I/O accesses.
    for (int t = 0; t < 80; t++) begin
      k    = $urandom_range(0, 5);
      addr = 16'($urandom);
      addr[15] = (k >= 3);
      run_txn(k == 0 || k == 2 || k == 3 || k == 5, k == 1 || k == 2 || k == 4 || k == 5,
              addr, 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
              16'($urandom), -1, din, stall, a0, a1);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
